// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM stage of the 5-stage MIPS pipeline (between EX and WB).
//
// Registers the EX-to-MEM bus, waits for load data from a variable-latency data
// SRAM (rvalid pulse), aligns/extends sub-word loads, drives the forwarding and
// stall-request outputs and builds the MEM-to-WB bus.
//
// Ports:
//   clk                 in   clock
//   rst                 in   synchronous active-high reset
//   stall[STALL_WD]     in   per-stage stall vector (bit 3 = MEM, bit 4 = WB)
//   ex_to_mem_bus       in   EX results {pc, data_ram_en, data_ram_wen, mem_op,
//                            mem_size, sel_rf_res, rf_we, rf_waddr, ex_result,
//                            rf_rdata2}
//   data_sram_rdata     in   load data
//   data_sram_rvalid    in   one-cycle pulse, one per issued load
//   mem_to_wb_bus       out  {pc, rf_we, rf_waddr, rf_wdata}
//   mem_we_o            out  forwarding write enable
//   mem_waddr_o         out  forwarding destination register
//   mem_wdata_o         out  forwarding data
//   mem_load_pending_o  out  1 while mem_wdata_o is not valid yet
//   stallreq            out  request to stop stages 0..3
//   mem_pc_o            out  debug PC
//   adel_o              out  sticky misaligned-access flag (only with
//                            MEM_UNALIGNED_CHECK_EN defined)
//
// Optional feature macro: MEM_UNALIGNED_CHECK_EN
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int EX_TO_MEM_WD = 112,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_we_o,
  output logic [4:0]              mem_waddr_o,
  output logic [31:0]             mem_wdata_o,
  output logic                    mem_load_pending_o,
  output logic                    stallreq,
  output logic [31:0]             mem_pc_o
`ifdef MEM_UNALIGNED_CHECK_EN
  ,
  output logic                    adel_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_load_f(input logic en, input logic [1:0] op);
    return en & ((op == 2'b01) | (op == 2'b10));
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; only real memory accesses.
  function automatic logic is_unaligned_f(input logic en, input logic [1:0] op,
                                          input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return en & (op != 2'b00) & bad;
  endfunction

  // Little-endian lane select plus sign (op 01) or zero (op 10) extension.
  function automatic logic [31:0] extract_f(input logic [31:0] rdata,
                                            input logic [1:0]  addr_lo,
                                            input logic [1:0]  size,
                                            input logic [1:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;
    logic [31:0] r;
    sgn = (op == 2'b01);
    case (addr_lo)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      2'b11:   b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [EX_TO_MEM_WD-1:0] bus_r;
  state_t                  state_r, state_nxt;
  logic                    load_issued_r;
  logic [31:0]             hold_buf_r;
  logic [7:0]              proto_err_cnt_r;
  logic                    hold_load_s;

  // Decoded fields of the registered instruction
  logic [31:0] pc_s;
  logic        en_s;
  logic [3:0]  wen_s;
  logic [1:0]  op_s;
  logic [1:0]  size_s;
  logic        sel_s;
  logic        we_s;
  logic [4:0]  waddr_s;
  logic [31:0] res_s;
  logic [31:0] rd2_s;

  assign pc_s    = bus_r[EX_TO_MEM_WD-1 -: 32];
  assign en_s    = bus_r[79];
  assign wen_s   = bus_r[78:75];
  assign op_s    = bus_r[74:73];
  assign size_s  = bus_r[72:71];
  assign sel_s   = bus_r[70];
  assign we_s    = bus_r[69];
  assign waddr_s = bus_r[68:64];
  assign res_s   = bus_r[63:32];
  assign rd2_s   = bus_r[31:0];

  // Store strobes/data go to the SRAM straight from EX; unused here.
  logic unused_s;
  assign unused_s = ^{wen_s, rd2_s, stall, proto_err_cnt_r};

  // Incoming instruction decode (needed to arm load_issued at capture time)
  logic in_is_load_s;
  logic in_fault_s;
  logic cur_fault_s;
  logic cur_is_load_s;

  assign in_is_load_s  = is_load_f(ex_to_mem_bus[79], ex_to_mem_bus[74:73]);
  assign cur_is_load_s = is_load_f(en_s, op_s);

`ifdef MEM_UNALIGNED_CHECK_EN
  assign in_fault_s  = is_unaligned_f(ex_to_mem_bus[79], ex_to_mem_bus[74:73],
                                      ex_to_mem_bus[72:71], ex_to_mem_bus[33:32]);
  assign cur_fault_s = is_unaligned_f(en_s, op_s, size_s, res_s[1:0]);
`else
  assign in_fault_s  = 1'b0;
  assign cur_fault_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake status
  // ---------------------------------------------------------------------------
  logic rvalid_used_s;  // rvalid belongs to the outstanding load
  logic load_wait_s;    // load outstanding and its data not here this cycle
  logic capture_s;      // register takes ex_to_mem_bus on this edge
  logic bubble_s;       // register is cleared on this edge
  logic advance_s;      // registered instruction leaves the stage this edge

  assign rvalid_used_s = data_sram_rvalid & load_issued_r;
  assign load_wait_s   = load_issued_r & ~data_sram_rvalid;
  // An outstanding load pins the register even if only stages 0..3 are
  // stopped; otherwise the MEM bubble would push it to WB without data.
  assign capture_s     = ~load_wait_s & ~stall[3];
  assign bubble_s      = ~load_wait_s & stall[3] & ~stall[4];
  assign advance_s     = ~stall[3] | ~stall[4];

  // Pipeline register: reset, bubble, capture or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r <= {EX_TO_MEM_WD{1'b0}};
    end else if (bubble_s) begin
      bus_r <= {EX_TO_MEM_WD{1'b0}};
    end else if (capture_s) begin
      bus_r <= ex_to_mem_bus;
    end else begin
      bus_r <= bus_r;
    end
  end

  // load_issued: armed by capturing an aligned load, cleared when its data shows up.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_issued_r <= 1'b0;
    end else if (capture_s && in_is_load_s && !in_fault_s) begin
      load_issued_r <= 1'b1;
    end else if (rvalid_used_s || bubble_s) begin
      load_issued_r <= 1'b0;
    end else begin
      load_issued_r <= load_issued_r;
    end
  end

  // Load FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Load FSM next state; data arriving while WB is stopped is parked in HOLD.
  always_comb begin
    state_nxt   = state_r;
    hold_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_issued_r && !data_sram_rvalid) begin
          state_nxt = ST_WAIT;
        end else if (rvalid_used_s && stall[4]) begin
          state_nxt   = ST_HOLD;
          hold_load_s = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!load_issued_r) begin
          state_nxt = ST_IDLE;
        end else if (rvalid_used_s && stall[4]) begin
          state_nxt   = ST_HOLD;
          hold_load_s = 1'b1;
        end else if (rvalid_used_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (advance_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_HOLD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Hold buffer keeps raw load data while WB is stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_buf_r <= 32'h0000_0000;
    end else if (hold_load_s) begin
      hold_buf_r <= data_sram_rdata;
    end else begin
      hold_buf_r <= hold_buf_r;
    end
  end

  // Saturating count of rvalid pulses that match no outstanding load.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_cnt_r <= 8'd0;
    end else if (data_sram_rvalid && !load_issued_r && (proto_err_cnt_r != 8'hFF)) begin
      proto_err_cnt_r <= proto_err_cnt_r + 8'd1;
    end else begin
      proto_err_cnt_r <= proto_err_cnt_r;
    end
  end

`ifdef MEM_UNALIGNED_CHECK_EN
  logic adel_r;

  // Sticky misaligned flag, set as the faulting instruction enters MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      adel_r <= 1'b0;
    end else if (capture_s && in_fault_s) begin
      adel_r <= 1'b1;
    end else begin
      adel_r <= adel_r;
    end
  end

  assign adel_o = adel_r;
`endif

  // ---------------------------------------------------------------------------
  // Result and outputs
  // ---------------------------------------------------------------------------
  logic [31:0] ld_src_s;
  logic [31:0] rf_wdata_s;
  logic        rf_we_s;

  assign ld_src_s   = (state_r == ST_HOLD) ? hold_buf_r : data_sram_rdata;
  assign rf_wdata_s = (sel_s & cur_is_load_s)
                      ? extract_f(ld_src_s, res_s[1:0], size_s, op_s)
                      : res_s;
  assign rf_we_s    = we_s & ~cur_fault_s;

  // WB sees a bubble while the load data is still missing.
  assign mem_to_wb_bus      = {pc_s, rf_we_s & ~load_wait_s, waddr_s, rf_wdata_s};
  assign mem_we_o           = rf_we_s;
  assign mem_waddr_o        = waddr_s;
  assign mem_wdata_o        = rf_wdata_s;
  assign mem_load_pending_o = load_wait_s;
  assign stallreq           = load_wait_s;
  assign mem_pc_o           = pc_s;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of EX and upstream of WB.
- Registers the EX-to-MEM bus and waits for load data from a data SRAM whose latency varies, using a valid handshake.
- Aligns and extends sub-word loads, and drives the forwarding and stall-request outputs.
- Builds the MEM-to-WB bus.

Parameters:
- EX_TO_MEM_WD, 112, input bus width. Fields, MSB to LSB: pc[32], data_ram_en[1], data_ram_wen[4], mem_op[2], mem_size[2], sel_rf_res[1], rf_we[1], rf_waddr[5], ex_result[32], rf_rdata2[32].
- MEM_TO_WB_WD, 70, output bus width. Fields, MSB to LSB: pc[32], rf_we[1], rf_waddr[5], rf_wdata[32].
- STALL_WD, 6, stall bus width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_WD  per-stage stall vector; 1 = Stop. Bit 3 = MEM, bit 4 = WB.
- ex_to_mem_bus  in  EX_TO_MEM_WD  EX results.
- data_sram_rdata  in  32  load data.
- data_sram_rvalid  in  1  one-cycle pulse, one per issued load.
- mem_to_wb_bus  out  MEM_TO_WB_WD  to WB.
- mem_we_o  out  1  forwarding write enable.
- mem_waddr_o  out  5  forwarding destination register.
- mem_wdata_o  out  32  forwarding data.
- mem_load_pending_o  out  1  1 while mem_wdata_o is not yet valid; ID must not forward from MEM.
- stallreq  out  1  request to stop stages 0..3.
- mem_pc_o  out  32  debug PC.

Behaviour:
- Pipeline register update, priority order:
  - rst: clear to 0.
  - stall[3]=1 and stall[4]=0: load bubble (all 0).
  - stall[3]=0: capture ex_to_mem_bus.
  - Otherwise: hold.
- Field decoding:
  - mem_op: 00 none, 01 load signed, 10 load unsigned, 11 store.
  - mem_size: 00 byte, 01 half, 10 word.
  - Address = ex_result.
  - is_load = data_ram_en & (mem_op==01 | mem_op==10).
- Load extraction (little-endian):
  - Byte: lane = addr[1:0], lane 0 = rdata[7:0].
  - Half: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
  - Word: rdata unchanged.
  - Sign-extend for op 01; zero-extend for op 10.
- Result select: rf_wdata = (sel_rf_res & is_load) ? load_data : ex_result.
- Load FSM states IDLE, WAIT, HOLD; reset state IDLE.
  - IDLE: new load instruction registered and rvalid=0 → WAIT. rvalid=1 in the same cycle → consume directly and stay IDLE.
  - WAIT: stallreq=1, mem_load_pending_o=1. rvalid=1 and stall[4]=0 → data used this cycle → IDLE. rvalid=1 and stall[4]=1 → latch into hold buffer → HOLD.
  - HOLD: data comes from the hold buffer; stallreq=0. When the stage advances (stall[3]=0) → IDLE.
- "New load" means the register captured a load on the previous edge. It is tracked by a 1-bit load_issued flag, set on capture and cleared once consumed. A held load already consumed does not re-enter WAIT.
- rvalid in IDLE with no outstanding load: ignored, counted as a protocol error and not used.
- Outputs:
  - mem_we_o = rf_we.
  - mem_waddr_o = rf_waddr.
  - mem_wdata_o = rf_wdata.
  - mem_pc_o = pc.
  - Stores and non-memory ops pass through with zero latency.
- Reset values: all outputs 0. FSM IDLE, hold buffer 0, load_issued 0.
- Reset mid-WAIT: return to IDLE. A late rvalid afterwards is ignored.
- Simultaneous events: rvalid in the same cycle as entry to WAIT counts as immediate completion. No bubble and no stallreq is raised.

Optional Feature:
- Macro MEM_UNALIGNED_CHECK_EN.
- Defined:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, sets sticky output adel_o (1 bit, new port). adel_o is cleared only by rst.
  - The faulting instruction has rf_we forced to 0 on both the bus and forwarding.
  - An unaligned load does not enter WAIT.
- Undefined: no adel_o port. Low address bits are ignored beyond lane select.

Test Plan:
- Word load at 0x100, rdata=0xDEADBEEF with rvalid 2 cycles late → stallreq=1 for exactly 2 cycles; pending=1 throughout; WB receives 0xDEADBEEF.
- Signed byte load at addr 0x103, rdata=0x80112233 → rf_wdata=0xFFFFFF80. Unsigned half at 0x102, same data → 0x00008011.
- Load with rvalid in the same cycle as capture → no stallreq, wdata valid immediately. Following ALU op (ex_result=0x5, rf_we=1) forwards 0x5 next cycle.
- rvalid arrives while stall[4]=1 → HOLD; rdata changed to 0x0 afterwards; on release WB still gets the latched 0xCAFEF00D.
- rst asserted in WAIT, rvalid pulsed the next cycle → all outputs 0; FSM IDLE; no write to WB.
- stall[3]=1 with stall[4]=0 → bubble reaches WB (rf_we=0). With MEM_UNALIGNED_CHECK_EN: word load at 0x102 → adel_o=1, rf_we=0, no stallreq.
